// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH flip-flops sharing a run-time SR/JK/D/T mode,
// with SR 11 detection, a sticky error flag and a saturating event count.
module multimode_ff_bank #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] illegal,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] ill_nxt;
  logic             event_hit;
  logic [CNT_W-1:0] cnt_base;

  always_comb begin
    q_nxt   = q;
    ill_nxt = '0;
    if (en) begin
      unique case (mode)
        MODE_SR: begin
          for (int i = 0; i < WIDTH; i++) begin
            unique case ({a[i], b[i]})
              2'b01:   q_nxt[i] = 1'b0;
              2'b10:   q_nxt[i] = 1'b1;
              2'b11:   ill_nxt[i] = 1'b1;
              default: q_nxt[i] = q[i];
            endcase
          end
        end
        MODE_JK: begin
          for (int i = 0; i < WIDTH; i++) begin
            unique case ({a[i], b[i]})
              2'b01:   q_nxt[i] = 1'b0;
              2'b10:   q_nxt[i] = 1'b1;
              2'b11:   q_nxt[i] = ~q[i];
              default: q_nxt[i] = q[i];
            endcase
          end
        end
        MODE_D:  q_nxt = a;
        MODE_T:  q_nxt = q ^ a;
        default: q_nxt = q;
      endcase
    end
  end

  assign event_hit = |ill_nxt;

  // Clear is applied before a same-edge event, so clear+event leaves 1.
  assign cnt_base = err_clr ? '0 : err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q          <= RESET_VAL;
      illegal    <= '0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      q       <= q_nxt;
      illegal <= ill_nxt;
      if (event_hit)
        err_sticky <= 1'b1;
      else if (err_clr)
        err_sticky <= 1'b0;
      if (event_hit && cnt_base != CNT_MAX)
        err_cnt <= cnt_base + 1'b1;
      else
        err_cnt <= cnt_base;
    end
  end

  assign qb = ~q;

endmodule
